// File: rtl/pwd_lock_core.sv
// Password-lock controller: digit entry, backspace, confirm, error counting,
// alarm lockout, timed unlock and admin key change. All outputs are registered.
module pwd_lock_core #(
   parameter int                        CODE_DIGITS   = 4,
   parameter int                        MAX_ERRORS    = 3,
   parameter int                        UNLOCK_CYCLES = 50000000,
   parameter int                        ERROR_CYCLES  = 25000000,
   parameter int                        ALARM_CYCLES  = 500000000,
   parameter int                        TIMER_W       = 32,
   parameter logic [4*CODE_DIGITS-1:0]  DEFAULT_KEY   = 16'h1234
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         digit_valid,
   input  logic [3:0]                   digit_value,
   input  logic                         ok_pulse,
   input  logic                         bksp_pulse,
   input  logic                         admin_pulse,
   output logic [2:0]                   state,
   output logic [4*CODE_DIGITS-1:0]     code,
   output logic [3:0]                   digit_cnt,
   output logic [3:0]                   err_cnt,
   output logic                         unlock,
   output logic                         alarm,
   output logic                         key_updated
);

   localparam int                 CW          = 4 * CODE_DIGITS;
   localparam logic [3:0]         CNT_FULL    = 4'(CODE_DIGITS);
   localparam logic [3:0]         ERR_LIMIT   = 4'(MAX_ERRORS);
   localparam logic [TIMER_W-1:0] UNLOCK_LAST = TIMER_W'(UNLOCK_CYCLES - 1);
   localparam logic [TIMER_W-1:0] ERROR_LAST  = TIMER_W'(ERROR_CYCLES - 1);
   localparam logic [TIMER_W-1:0] ALARM_LAST  = TIMER_W'(ALARM_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ZERO  = {TIMER_W{1'b0}};
   localparam logic [TIMER_W-1:0] TIMER_ONE   = {{(TIMER_W-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      CODE_ZERO   = {CW{1'b0}};

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_INPUT  = 3'd1,
      S_UNLOCK = 3'd2,
      S_ERROR  = 3'd3,
      S_ALARM  = 3'd4,
      S_ADMIN  = 3'd5
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [CW-1:0]       code_r, code_nxt_s;
   logic [CW-1:0]       key_r, key_nxt_s;
   logic [3:0]          digit_cnt_r, cnt_nxt_s;
   logic [3:0]          err_cnt_r, err_nxt_s;
   logic [TIMER_W-1:0]  timer_r, timer_nxt_s;
   logic                unlock_r, alarm_r, key_updated_r, key_upd_s;

   logic                ev_admin_s, ev_ok_s, ev_bksp_s, ev_digit_s;
   logic                full_s, digit_acc_s, bksp_acc_s;
   logic [CW-1:0]       code_shl_s, code_shr_s;
   logic [3:0]          err_inc_s;

   // Only the highest-priority pulse of a cycle is considered.
   assign ev_admin_s  = admin_pulse;
   assign ev_ok_s     = ok_pulse & ~admin_pulse;
   assign ev_bksp_s   = bksp_pulse & ~ok_pulse & ~admin_pulse;
   assign ev_digit_s  = digit_valid & ~bksp_pulse & ~ok_pulse & ~admin_pulse;

   assign full_s      = (digit_cnt_r == CNT_FULL);
   assign digit_acc_s = ev_digit_s & (digit_value <= 4'd9) & ~full_s;
   assign bksp_acc_s  = ev_bksp_s & (digit_cnt_r != 4'd0);
   assign code_shl_s  = CW'({code_r, digit_value});
   assign code_shr_s  = code_r >> 3'd4;
   assign err_inc_s   = err_cnt_r + 4'd1;

   // Next-state, datapath and timer decode.
   always_comb begin
      state_nxt_s = state_r;
      code_nxt_s  = code_r;
      cnt_nxt_s   = digit_cnt_r;
      err_nxt_s   = err_cnt_r;
      key_nxt_s   = key_r;
      key_upd_s   = 1'b0;
      timer_nxt_s = TIMER_ZERO;
      case (state_r)
         S_WAIT: begin
            if (digit_acc_s) begin
               code_nxt_s  = code_shl_s;
               cnt_nxt_s   = digit_cnt_r + 4'd1;
               state_nxt_s = S_INPUT;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_INPUT: begin
            if (ev_ok_s) begin
               code_nxt_s = CODE_ZERO;
               cnt_nxt_s  = 4'd0;
               if (full_s && (code_r == key_r)) begin
                  err_nxt_s   = 4'd0;
                  state_nxt_s = S_UNLOCK;
               end else if (err_inc_s == ERR_LIMIT) begin
                  err_nxt_s   = err_inc_s;
                  state_nxt_s = S_ALARM;
               end else begin
                  err_nxt_s   = err_inc_s;
                  state_nxt_s = S_ERROR;
               end
            end else if (bksp_acc_s) begin
               code_nxt_s  = code_shr_s;
               cnt_nxt_s   = digit_cnt_r - 4'd1;
               state_nxt_s = (digit_cnt_r == 4'd1) ? S_WAIT : S_INPUT;
            end else if (digit_acc_s) begin
               code_nxt_s = code_shl_s;
               cnt_nxt_s  = digit_cnt_r + 4'd1;
            end else begin
               state_nxt_s = S_INPUT;
            end
         end
         S_UNLOCK: begin
            if (ev_ok_s) begin
               state_nxt_s = S_WAIT;
            end else if (ev_admin_s) begin
               code_nxt_s  = CODE_ZERO;
               cnt_nxt_s   = 4'd0;
               state_nxt_s = S_ADMIN;
            end else if (timer_r == UNLOCK_LAST) begin
               state_nxt_s = S_WAIT;
            end else begin
               timer_nxt_s = timer_r + TIMER_ONE;
            end
         end
         S_ERROR: begin
            if (timer_r == ERROR_LAST) begin
               state_nxt_s = S_WAIT;
            end else begin
               timer_nxt_s = timer_r + TIMER_ONE;
            end
         end
         S_ALARM: begin
            if (timer_r == ALARM_LAST) begin
               err_nxt_s   = 4'd0;
               state_nxt_s = S_WAIT;
            end else begin
               timer_nxt_s = timer_r + TIMER_ONE;
            end
         end
         S_ADMIN: begin
            // Abort and commit both leave an empty entry buffer behind.
            if (ev_admin_s) begin
               code_nxt_s  = CODE_ZERO;
               cnt_nxt_s   = 4'd0;
               state_nxt_s = S_WAIT;
            end else if (ev_ok_s && full_s) begin
               key_nxt_s   = code_r;
               key_upd_s   = 1'b1;
               code_nxt_s  = CODE_ZERO;
               cnt_nxt_s   = 4'd0;
               state_nxt_s = S_WAIT;
            end else if (bksp_acc_s) begin
               code_nxt_s = code_shr_s;
               cnt_nxt_s  = digit_cnt_r - 4'd1;
            end else if (digit_acc_s) begin
               code_nxt_s = code_shl_s;
               cnt_nxt_s  = digit_cnt_r + 4'd1;
            end else begin
               state_nxt_s = S_ADMIN;
            end
         end
         default: begin
            code_nxt_s  = CODE_ZERO;
            cnt_nxt_s   = 4'd0;
            state_nxt_s = S_WAIT;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r       <= S_WAIT;
         code_r        <= CODE_ZERO;
         key_r         <= DEFAULT_KEY;
         digit_cnt_r   <= 4'd0;
         err_cnt_r     <= 4'd0;
         timer_r       <= TIMER_ZERO;
         unlock_r      <= 1'b0;
         alarm_r       <= 1'b0;
         key_updated_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         code_r        <= code_nxt_s;
         key_r         <= key_nxt_s;
         digit_cnt_r   <= cnt_nxt_s;
         err_cnt_r     <= err_nxt_s;
         timer_r       <= timer_nxt_s;
         unlock_r      <= (state_nxt_s == S_UNLOCK);
         alarm_r       <= (state_nxt_s == S_ALARM);
         key_updated_r <= key_upd_s;
      end
   end

   assign state       = state_r;
   assign code        = code_r;
   assign digit_cnt   = digit_cnt_r;
   assign err_cnt     = err_cnt_r;
   assign unlock      = unlock_r;
   assign alarm       = alarm_r;
   assign key_updated = key_updated_r;

endmodule
